// File: rtl/write_logic_regs_header.sv
// write_logic_regs_header
// Write side of the 4-line header/packet store. Takes a byte-wide AXI-Stream
// packet and produces registered byte writes ({line, char} pointer, byte
// strobe, last-byte chip select). Committed lines are counted against
// release pulses from the reader. New packets are held off while all lines
// are committed.
// Optional build macro: TRUNC_COUNT_EN adds trunc_cnt[15:0], a saturating
// count of packets truncated at MAX_CHAR.
`timescale 1ns/1ps

module write_logic_regs_header #(
  parameter int          LINES    = 4,       // must be 4 to match the 2-bit line field
  parameter logic [10:0] MAX_CHAR = 11'h7FF  // last writable char index in a line
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  input  logic        rd_line_release,
  output logic [12:0] wr_ptr_rgs,
  output logic        we_rgs,
  output logic [7:0]  tdata_rgs,
  output logic        tlastarray_cs_rgs,
  output logic [2:0]  line_count,
  output logic        lines_full
`ifdef TRUNC_COUNT_EN
  ,
  output logic [15:0] trunc_cnt
`endif
);

  localparam logic [2:0] LINES_C = 3'(LINES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DROP  = 2'd2
  } state_t;

  state_t      state_q;
  logic [1:0]  wr_line_q;
  logic [10:0] wr_char_q;
  logic [2:0]  line_count_q;
  logic [2:0]  line_count_d;
  logic        lines_full_q;
  logic        we_q;
  logic        cs_q;
  logic [7:0]  tdata_q;
  logic [12:0] ptr_q;

  logic accept;    // beat handshake this cycle
  logic writing;   // accepted beat that lands in the store
  logic at_max;    // current char is the last one a line can hold
  logic terminal;  // written beat that closes the line (tlast or truncation)

  // Once a packet has started it always has a line to finish in, so only a
  // packet start (IDLE) waits for a free line.
  assign s_axis_tready = (state_q != IDLE) || !lines_full_q;

  assign accept   = s_axis_tvalid && s_axis_tready;
  assign writing  = accept && (state_q != DROP);
  assign at_max   = (wr_char_q == MAX_CHAR);
  assign terminal = writing && (s_axis_tlast || at_max);

  // Next committed-line count: commit and release cancel, release at zero is ignored.
  always_comb begin
    line_count_d = line_count_q;
    if (terminal && !rd_line_release) begin
      line_count_d = line_count_q + 3'd1;
    end else if (!terminal && rd_line_release && (line_count_q != 3'd0)) begin
      line_count_d = line_count_q - 3'd1;
    end
  end

  // Packet FSM, write pointer, registered store outputs and line occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_line_q    <= 2'd0;
      wr_char_q    <= 11'd0;
      line_count_q <= 3'd0;
      lines_full_q <= 1'b0;
      we_q         <= 1'b0;
      cs_q         <= 1'b0;
      tdata_q      <= 8'd0;
      ptr_q        <= 13'd0;
    end else begin
      we_q         <= writing;
      cs_q         <= terminal;
      line_count_q <= line_count_d;
      lines_full_q <= (line_count_d == LINES_C);

      if (writing) begin
        tdata_q <= s_axis_tdata;
        ptr_q   <= {wr_line_q, wr_char_q};
        if (terminal) begin
          wr_char_q <= 11'd0;
          wr_line_q <= wr_line_q + 2'd1;
        end else begin
          wr_char_q <= wr_char_q + 11'd1;
        end
      end

      if (accept) begin
        case (state_q)
          IDLE, WRITE: begin
            if (s_axis_tlast)  state_q <= IDLE;
            else if (at_max)   state_q <= DROP;
            else               state_q <= WRITE;
          end
          DROP: begin
            if (s_axis_tlast)  state_q <= IDLE;
          end
          default:             state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef TRUNC_COUNT_EN
  logic [15:0] trunc_cnt_q;

  // One count per packet that overflows its line; holds at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      trunc_cnt_q <= 16'd0;
    end else if (writing && at_max && !s_axis_tlast && (trunc_cnt_q != 16'hFFFF)) begin
      trunc_cnt_q <= trunc_cnt_q + 16'd1;
    end
  end

  assign trunc_cnt = trunc_cnt_q;
`endif

  assign wr_ptr_rgs        = ptr_q;
  assign we_rgs            = we_q;
  assign tdata_rgs         = tdata_q;
  assign tlastarray_cs_rgs = cs_q;
  assign line_count        = line_count_q;
  assign lines_full        = lines_full_q;

endmodule
